trng_collector: RTL and testbench

Consumer end of the TRNG bit stream. Samples the generator's `random` bit on each rising edge of its `bclk` strobe, gated by the generator's metastability-lock indicator. Runs a repetition-count health test on the raw bits, optionally applies von Neumann debiasing, and packs the accepted bits into words. Words are delivered through a small FIFO with a valid/ready handshake to the system bus or a UART.

---
 rtl/trng_collector.sv | 242 ++++++++++++++++++++++++
 tb/tb_trng_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/trng_collector.sv
// trng_collector
//
// Consumer end of the TRNG bit stream. The generator's bclk/random/lock
// signals are synchronized into clk. Each bclk rising edge samples one raw
// bit, but only while lock is high. The raw bits pass a repetition-count
// health test and are optionally von Neumann debiased. The surviving bits
// are packed MSB-first into WORD_W-bit words, which are delivered through a
// FIFO with a valid/ready handshake.
//
// Optional feature:
//   TRNG_VN_DEBIAS_EN defined   - raw bits are paired: 01 -> 0, 10 -> 1,
//                                 and 00/11 are discarded
//   TRNG_VN_DEBIAS_EN undefined - every accepted raw bit is packed directly
//
// Parameters:
//   WORD_W      output word width (2..16)
//   FIFO_DEPTH  FIFO entries, power of two (2..16)
//   REP_LIMIT   consecutive identical raw bits that trip the health test (2..255)
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   bclk         generator bit strobe (async); a rising edge marks a new bit
//   random       generator random bit (async)
//   lock         generator metastable-lock flag (async); high = bits usable
//   out_data     FIFO head word
//   out_valid    FIFO not empty
//   out_ready    consumer accepts out_data
//   level        FIFO occupancy
//   drop_cnt     words lost to a full FIFO, saturating at 255
//   health_fail  sticky repetition-test failure

module trng_collector #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          bclk,
    input  logic                          random,
    input  logic                          lock,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [7:0]                    drop_cnt,
    output logic                          health_fail
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(WORD_W);

    // ------------------------------------------------------------------
    // Synchronizers and strobe edge detect
    // ------------------------------------------------------------------
    logic bclk_s1, bclk_s2, bclk_s3;
    logic rnd_s1, rnd_s2;
    logic lock_s1, lock_s2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            rnd_s1  <= 1'b0;
            rnd_s2  <= 1'b0;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            bclk_s1 <= bclk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            rnd_s1  <= random;
            rnd_s2  <= rnd_s1;
            lock_s1 <= lock;
            lock_s2 <= lock_s1;
        end
    end

    logic stb;
    logic raw_bit;
    logic take;

    assign stb     = bclk_s2 & ~bclk_s3;
    assign raw_bit = rnd_s2;
    assign take    = stb & lock_s2 & ~health_fail;

    // ------------------------------------------------------------------
    // Repetition-count health test
    // ------------------------------------------------------------------
    logic [7:0] rep_cnt;
    logic       prev_bit;
    logic [7:0] rep_next;
    logic       rep_trip;
    logic       pass_valid;

    // rep_cnt == 0 marks "no previous bit" after reset or lock loss, so the
    // first bit of a run always starts counting at 1.
    always_comb begin
        rep_next = 8'd1;
        if (rep_cnt != 8'd0 && raw_bit == prev_bit) begin
            rep_next = rep_cnt + 8'd1;
        end
    end

    assign rep_trip   = take & (rep_next == 8'(REP_LIMIT));
    assign pass_valid = take & ~rep_trip;

    // ------------------------------------------------------------------
    // Optional von Neumann debiasing
    // ------------------------------------------------------------------
    logic pack_valid;
    logic pack_bit;

`ifdef TRNG_VN_DEBIAS_EN
    logic pair_have;
    logic pair_first;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pair_have  <= 1'b0;
            pair_first <= 1'b0;
        end else if (!lock_s2 || health_fail || rep_trip) begin
            pair_have  <= 1'b0;
            pair_first <= 1'b0;
        end else if (pass_valid) begin
            if (!pair_have) begin
                pair_have  <= 1'b1;
                pair_first <= raw_bit;
            end else begin
                pair_have  <= 1'b0;
            end
        end
    end

    // A pair 01 emits 0 and a pair 10 emits 1, so the emitted bit is the
    // first bit of the pair.
    assign pack_valid = pass_valid & pair_have & (pair_first != raw_bit);
    assign pack_bit   = pair_first;
`else
    assign pack_valid = pass_valid;
    assign pack_bit   = raw_bit;
`endif

    // ------------------------------------------------------------------
    // Word packer
    // ------------------------------------------------------------------
    logic [CW-1:0]     bit_cnt;
    logic [WORD_W-1:0] word_sr;
    logic              word_last;
    logic [WORD_W-1:0] push_word;
    logic              push_req;

    assign word_last = (bit_cnt == CW'(WORD_W - 1));
    assign push_word = {word_sr[WORD_W-2:0], pack_bit};
    assign push_req  = pack_valid & word_last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rep_cnt     <= '0;
            prev_bit    <= 1'b0;
            bit_cnt     <= '0;
            word_sr     <= '0;
            health_fail <= 1'b0;
        end else if (!lock_s2) begin
            rep_cnt <= '0;
            bit_cnt <= '0;
            word_sr <= '0;
        end else if (health_fail) begin
            bit_cnt <= '0;
            word_sr <= '0;
        end else if (take) begin
            rep_cnt  <= rep_next;
            prev_bit <= raw_bit;
            if (rep_trip) begin
                // The tripping bit is never packed.
                health_fail <= 1'b1;
                bit_cnt     <= '0;
                word_sr     <= '0;
            end else if (pack_valid) begin
                word_sr <= push_word;
                if (word_last) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = out_valid & out_ready;
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & ~push_ok;

    // The storage array is registered, so the head read below is a register
    // value and stays stable until a pop moves rd_ptr. On a push into a full
    // FIFO with a simultaneous pop, the write lands in the slot being popped,
    // which is only visible after the edge.
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign out_valid = ~empty;
    assign level     = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_word;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// Testbench for trng_collector (WORD_W=8, FIFO_DEPTH=4, REP_LIMIT=16).
// Expected words go into a scoreboard queue when stimulus is driven. A
// monitor pops the queue and compares each word the DUT hands over.

module tb_trng_collector;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       bclk = 1'b0;
    logic       random = 1'b0;
    logic       lock = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] level;
    logic [7:0] drop_cnt;
    logic       health_fail;

    int         checks = 0;
    int         errors = 0;
    int         valid_cycles = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic [7:0] stim;
        logic [7:0] exp_word;
        int         exp_level;
    } vec_t;

    vec_t vecs [8];

    trng_collector #(
        .WORD_W     (8),
        .FIFO_DEPTH (4),
        .REP_LIMIT  (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bclk        (bclk),
        .random      (random),
        .lock        (lock),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .drop_cnt    (drop_cnt),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One generator bit period of 16 clk: bclk high for 8, low for 8.
    task automatic send_bit(input logic b);
        @(negedge clk);
        random = b;
        bclk   = 1'b1;
        repeat (8) @(negedge clk);
        bclk = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic reset_checks();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_health_fail", health_fail, 0);
    endtask

    initial begin
        vecs[0] = '{stim: 8'hB2, exp_word: 8'hB2, exp_level: 0};
        vecs[1] = '{stim: 8'h5A, exp_word: 8'h5A, exp_level: 0};
        vecs[2] = '{stim: 8'h3C, exp_word: 8'h3C, exp_level: 0};
        vecs[3] = '{stim: 8'hC3, exp_word: 8'hC3, exp_level: 0};
        vecs[4] = '{stim: 8'hF0, exp_word: 8'hF0, exp_level: 0};
        vecs[5] = '{stim: 8'h0F, exp_word: 8'h0F, exp_level: 0};
        vecs[6] = '{stim: 8'h81, exp_word: 8'h81, exp_level: 0};
        vecs[7] = '{stim: 8'h7E, exp_word: 8'h7E, exp_level: 0};

        // Monitor: samples 1 time unit after the falling edge, once the
        // inputs for the coming rising edge are settled.
        fork
            forever begin
                logic [7:0] exp_w;
                @(negedge clk);
                #1;
                if (resetn && out_valid) valid_cycles++;
                if (resetn && out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h expected no word", out_data);
                    end else begin
                        exp_w = sb.pop_front();
                        check("sb_word", out_data, exp_w);
                    end
                end
            end
        join_none

        // Reset state
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        resetn = 1'b1;
        repeat (4) @(negedge clk);

`ifdef TRNG_VN_DEBIAS_EN
        // Raw groups 0,1,1,0,1,1,0,0 emit 0,1 each, giving the word 0x55.
        begin
            logic [7:0] grp;
            grp = 8'b0110_1100;
            sb.push_back(8'h55);
            for (int g = 0; g < 4; g++) begin
                send_word(grp);
            end
            repeat (4) @(negedge clk);
            check("vn_level", level, 0);
            check("vn_drop_cnt", drop_cnt, 0);
            check("vn_health", health_fail, 0);
            check("vn_sb_drained", sb.size(), 0);
        end
`else
        // Table: words streamed with out_ready=1
        valid_cycles = 0;
        for (int v = 0; v < 8; v++) begin
            sb.push_back(vecs[v].exp_word);
            send_word(vecs[v].stim);
            repeat (4) @(negedge clk);
            check("tbl_level", level, vecs[v].exp_level);
            if (v == 0) check("valid_pulse_cycles", valid_cycles, 1);
        end

        // Backpressure: the fifth word is dropped
        out_ready = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            logic [7:0] wv;
            wv = 8'(w);
            if (w <= 4) sb.push_back(wv);
            send_word(wv);
        end
        repeat (4) @(negedge clk);
        check("bp_level", level, 4);
        check("bp_drop_cnt", drop_cnt, 1);
        check("bp_out_data", out_data, 8'h01);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_drained_level", level, 0);
        check("bp_sb_drained", sb.size(), 0);

        // Lock loss discards a partial word
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        lock = 1'b0;
        repeat (10) @(negedge clk);
        lock = 1'b1;
        repeat (10) @(negedge clk);
        check("lock_no_word", level, 0);
        sb.push_back(8'hA5);
        send_word(8'hA5);
        repeat (4) @(negedge clk);
        check("lock_sb_drained", sb.size(), 0);

        // Reset with three queued words and a partial word
        out_ready = 1'b0;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h33);
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("pre_rst_level", level, 3);
        resetn = 1'b0;
        @(negedge clk);
        reset_checks();
        sb.delete();
        resetn = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        sb.push_back(8'h96);
        send_word(8'h96);
        repeat (4) @(negedge clk);
        check("post_rst_sb_drained", sb.size(), 0);

        // Repetition test: 16 identical bits trip health_fail
        out_ready = 1'b0;
        sb.push_back(8'h96);
        send_word(8'h96);
        sb.push_back(8'hFF);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("health_before_16th", health_fail, 0);
            send_bit(1'b1);
        end
        check("health_after_16th", health_fail, 1);
        check("health_level", level, 2);
        send_word(8'h5A);
        check("health_no_new_words", level, 2);
        check("health_sticky", health_fail, 1);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("health_drained_level", level, 0);
        check("health_drained_valid", out_valid, 0);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
